// File: rtl/change_pkg.sv
// Shared types and defaults for the coin-return unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package change_pkg;

  // Default width of the change amount and coin counter.
  localparam int COIN_W_DEFAULT = 4;

  // Payout sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EJECT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Larger of two interval lengths, used to size the shared timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/change_dispenser_cycle_timer.sv
// Loadable down-counter with a zero flag, shared by pulse and gap intervals.
// Latency: load or decrement takes effect on the next clock edge.
// Backpressure: none; holds at zero when decremented past the end.
module cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over decrement; never wraps below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out a coin count as timed eject pulses, with cancel and completion pulse.
// Latency: coin_eject rises one cycle after an accepted load; done one cycle after the last pulse.
// Backpressure: load is ignored while busy; cancel stops after the current pulse or at once in a gap.
module change_dispenser
  import change_pkg::*;
#(
  parameter int COIN_W       = COIN_W_DEFAULT,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [COIN_W-1:0] change,
  input  logic              cancel,
  output logic              coin_eject,
  output logic              busy,
  output logic [COIN_W-1:0] coins_left,
  output logic              done
);

  localparam int TW = $clog2(max_int(PULSE_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);

  state_t        state;
  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_dec;
  logic          t_zero;
  logic          last_coin;

  assign last_coin = (coins_left == COIN_W'(1));

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  // Timer control: reload at each interval boundary, otherwise count down while paying.
  always_comb begin
    t_load = 1'b0;
    t_val  = PULSE_LD;
    t_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (load && (change != '0)) begin
          t_load = 1'b1;
          t_val  = PULSE_LD;
        end
      end
      EJECT: begin
        if (t_zero) begin
          if (!(last_coin || cancel)) begin
            t_load = 1'b1;
            t_val  = GAP_LD;
          end
        end else begin
          t_dec = 1'b1;
        end
      end
      GAP: begin
        if (!cancel) begin
          if (t_zero) begin
            t_load = 1'b1;
            t_val  = PULSE_LD;
          end else begin
            t_dec = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Payout sequencer; outputs are registered alongside the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      coin_eject <= 1'b0;
      busy       <= 1'b0;
      coins_left <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            busy <= 1'b1;
            if (change != '0) begin
              coins_left <= change;
              coin_eject <= 1'b1;
              state      <= EJECT;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        EJECT: begin
          // A pulse always runs to full length; cancel is honoured only at its end.
          if (t_zero) begin
            coins_left <= coins_left - COIN_W'(1);
            coin_eject <= 1'b0;
            if (last_coin || cancel) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (cancel) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (t_zero) begin
            coin_eject <= 1'b1;
            state      <= EJECT;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          coin_eject <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser with PULSE_CYCLES=2, GAP_CYCLES=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_change_dispenser;

  localparam int CW = 4;
  localparam int P  = 2;
  localparam int G  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [CW-1:0] change = '0;
  logic          cancel = 1'b0;
  logic          coin_eject;
  logic          busy;
  logic [CW-1:0] coins_left;
  logic          done;

  change_dispenser #(
    .COIN_W       (CW),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .change     (change),
    .cancel     (cancel),
    .coin_eject (coin_eject),
    .busy       (busy),
    .coins_left (coins_left),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: payout described by elapsed time inside a transaction.
  bit m_pay, m_done;
  int m_el, m_total, m_paid;

  function automatic void model_reset();
    m_pay = 0; m_done = 0; m_el = 0; m_total = 0; m_paid = 0;
  endfunction

  function automatic void model_edge(input bit ld, input int ch, input bit cn);
    int ph;
    if (m_pay) begin
      ph = m_el % (P + G);
      if (ph < P) begin
        if (ph == P - 1) begin
          m_paid++;
          if (m_paid == m_total || cn) begin m_pay = 0; m_done = 1; end
          else m_el++;
        end else m_el++;
      end else begin
        if (cn) begin m_pay = 0; m_done = 1; end
        else m_el++;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (ld) begin
      if (ch != 0) begin
        m_pay = 1; m_el = 0; m_total = ch; m_paid = 0;
      end else m_done = 1;
    end
  endfunction

  int  pulses, eject_cycles;
  bit  prev_eject;

  // Drive inputs (caller at negedge), advance one edge, compare at the next negedge.
  task automatic step(input bit ld, input int ch, input bit cn);
    load = ld; change = CW'(ch); cancel = cn;
    @(posedge clk);
    model_edge(ld, ch, cn);
    @(negedge clk);
    check("eject",      int'(coin_eject), int'(m_pay && ((m_el % (P + G)) < P)));
    check("busy",       int'(busy),       int'(m_pay || m_done));
    check("coins_left", int'(coins_left), m_total - m_paid);
    check("done",       int'(done),       int'(m_done));
    if (coin_eject && !prev_eject) pulses++;
    if (coin_eject) eject_cycles++;
    prev_eject = coin_eject;
  endtask

  typedef struct {
    bit ld; int ch; bit cn;
    bit e_eject; bit e_busy; int e_left; bit e_done;
  } vec_t;

  vec_t vt[22];

  task automatic run_to_done(input string name, input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      step(0, 0, 0);
      n++;
    end
    check({name, "_timeout"}, int'(done), 1);
  endtask

  initial begin
    bit cancelled;
    int n;
    model_reset();
    prev_eject = 0;

    // Reset state
    #2;
    check("rst_eject", int'(coin_eject), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_left",  int'(coins_left), 0);
    check("rst_done",  int'(done), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // change=3 timeline, change=0, then load+cancel together with change=1
    vt[0]  = '{1,3,0, 1,1,3,0};
    vt[1]  = '{0,0,0, 1,1,3,0};
    vt[2]  = '{0,0,0, 0,1,2,0};
    vt[3]  = '{0,0,0, 0,1,2,0};
    vt[4]  = '{0,0,0, 0,1,2,0};
    vt[5]  = '{0,0,0, 1,1,2,0};
    vt[6]  = '{0,0,0, 1,1,2,0};
    vt[7]  = '{0,0,0, 0,1,1,0};
    vt[8]  = '{0,0,0, 0,1,1,0};
    vt[9]  = '{0,0,0, 0,1,1,0};
    vt[10] = '{0,0,0, 1,1,1,0};
    vt[11] = '{0,0,0, 1,1,1,0};
    vt[12] = '{0,0,0, 0,1,0,1};
    vt[13] = '{0,0,0, 0,0,0,0};
    vt[14] = '{1,0,0, 0,1,0,1};
    vt[15] = '{0,0,0, 0,0,0,0};
    vt[16] = '{0,0,0, 0,0,0,0};
    vt[17] = '{1,1,1, 1,1,1,0};
    vt[18] = '{0,0,1, 1,1,1,0};
    vt[19] = '{0,0,1, 0,1,0,1};
    vt[20] = '{0,0,0, 0,0,0,0};
    vt[21] = '{0,0,0, 0,0,0,0};
    for (int i = 0; i < 22; i++) begin
      step(vt[i].ld, vt[i].ch, vt[i].cn);
      check($sformatf("vec%0d_eject", i), int'(coin_eject), int'(vt[i].e_eject));
      check($sformatf("vec%0d_busy", i),  int'(busy),       int'(vt[i].e_busy));
      check($sformatf("vec%0d_left", i),  int'(coins_left), vt[i].e_left);
      check($sformatf("vec%0d_done", i),  int'(done),       int'(vt[i].e_done));
    end

    // Asynchronous reset in the middle of a pulse
    step(1, 3, 0);
    step(0, 0, 0);
    check("pre_rst_eject", int'(coin_eject), 1);
    #2 rst = 1'b1;
    #1;
    check("async_eject", int'(coin_eject), 0);
    check("async_busy",  int'(busy), 0);
    check("async_left",  int'(coins_left), 0);
    check("async_done",  int'(done), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    prev_eject = 0;
    step(0, 0, 0);
    check("post_rst_idle", int'(busy), 0);

    // change=5, cancel during the second gap
    pulses = 0; cancelled = 0; n = 0;
    step(1, 5, 0);
    while (!done && n < 100) begin
      if (pulses == 2 && !coin_eject && !cancelled) begin
        cancelled = 1;
        step(0, 0, 1);
        check("gap_cancel_done_next", int'(done), 1);
      end else step(0, 0, 0);
      n++;
    end
    check("gap_cancel_timeout", int'(done), 1);
    check("gap_cancel_pulses", pulses, 2);
    step(0, 0, 0); step(0, 0, 0);
    check("gap_cancel_left_held", int'(coins_left), 3);

    // change=4, cancel raised in the first pulse cycle and held
    pulses = 0; eject_cycles = 0; n = 0;
    step(1, 4, 0);
    while (!done && n < 100) begin step(0, 0, 1); n++; end
    check("ej_cancel_timeout", int'(done), 1);
    check("ej_cancel_pulses", pulses, 1);
    check("ej_cancel_width", eject_cycles, P);
    check("ej_cancel_left", int'(coins_left), 3);
    step(0, 0, 0);

    // Load while busy is ignored; a fresh load afterwards is accepted
    pulses = 0; n = 0;
    step(1, 2, 0);
    while (!done && n < 100) begin step(1, 7, 0); n++; end
    check("busy_load_timeout", int'(done), 1);
    check("busy_load_pulses", pulses, 2);
    check("busy_load_left", int'(coins_left), 0);
    step(0, 0, 0);
    pulses = 0;
    step(1, 7, 0);
    run_to_done("fresh7", 200);
    check("fresh7_pulses", pulses, 7);
    step(0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
